// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage between the EX/MEM and MEM/WB latches.
// Issues byte-lane requests on a variable-latency data-memory handshake,
// aligns and extends load data, flags misaligned accesses and stalls the
// upstream pipeline while an access is outstanding.

package mem_stage_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  // From EX/MEM
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     write_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
  input  logic                      reg_write_in,
  input  logic                      mem_to_reg_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_unsigned_in,
  // Data-memory handshake
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  output logic [3:0]                dmem_be,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  // To MEM/WB
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [REG_ADDR_WIDTH-1:0] write_register_out,
  output logic                      mem_to_reg_out,
  output logic [DATA_WIDTH-1:0]     read_data_out,
  output logic                      reg_write_out,
  // Pipeline control
  output logic                      stall_out,
  output logic                      misaligned_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Access decode
  logic       is_byte, is_half, is_word;
  logic [1:0] byte_off;
  logic       mem_access;
  logic       misaligned;
  logic       mem_op;

  assign is_byte    = (mem_size_in == SIZE_BYTE);
  assign is_half    = (mem_size_in == SIZE_HALF);
  assign is_word    = mem_size_in[1];           // 10 and 11 both mean word
  assign byte_off   = alu_result_in[1:0];
  assign mem_access = mem_read_in | mem_write_in;
  assign misaligned = mem_access & ((is_half & byte_off[0]) |
                                    (is_word & (byte_off != 2'b00)));
  assign mem_op     = mem_access & ~misaligned;

  // Handshake / control strobes from the FSM
  logic req_c, stall_c, capture_c, done_c;

  // Lane-replicated store data and byte enables for the current access
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [3:0]            lane_be;

  // Lane data, byte/half selection and extension of the captured word
  logic [7:0]            rd_byte [4];
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [DATA_WIDTH-1:0] load_ext;

  // State register; reset drops any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read-data capture on an accepted acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (capture_c) begin
      rdata_q <= dmem_rdata;
    end
  end

  // Next-state and handshake control; acks with no request outstanding are ignored
  always_comb begin
    state_d   = state_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    capture_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          if (dmem_ack) begin
            capture_c = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dmem_ack) begin
          capture_c = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // EX/MEM advances at the end of this cycle; never reissue
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // During reset the stage looks like an idle, non-memory instruction
    if (reset) begin
      req_c     = 1'b0;
      stall_c   = 1'b0;
      capture_c = 1'b0;
      done_c    = 1'b0;
    end
  end

  // Store lane steering: replicate data across lanes, enable only the touched bytes
  always_comb begin
    lane_wdata = write_data_in;
    lane_be    = 4'b1111;
    if (is_byte) begin
      lane_wdata = {4{write_data_in[7:0]}};
      lane_be    = 4'b0001 << byte_off;
    end else if (is_half) begin
      lane_wdata = {2{write_data_in[15:0]}};
      lane_be    = byte_off[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Split the captured word into little-endian byte lanes
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_byte[gi] = rdata_q[8*gi +: 8];
  end

  // Load alignment and sign/zero extension from the captured word
  always_comb begin
    sel_byte = rd_byte[byte_off];
    sel_half = byte_off[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext = rdata_q;
    if (is_byte) begin
      load_ext = {{24{~mem_unsigned_in & sel_byte[7]}}, sel_byte};
    end else if (is_half) begin
      load_ext = {{16{~mem_unsigned_in & sel_half[15]}}, sel_half};
    end
  end

  // Memory interface; address and lanes follow the held EX/MEM inputs
  assign dmem_req   = req_c;
  assign dmem_we    = req_c & mem_write_in;
  assign dmem_addr  = {alu_result_in[DATA_WIDTH-1:2], 2'b00};
  assign dmem_wdata = lane_wdata;
  assign dmem_be    = req_c ? lane_be : 4'b0000;

  // MEM/WB side: bubble while stalled, suppress writeback for misaligned accesses
  assign alu_result_out     = alu_result_in;
  assign write_register_out = write_register_in;
  assign mem_to_reg_out     = mem_to_reg_in;
  assign read_data_out      = done_c ? load_ext : '0;
  assign reg_write_out      = ~stall_c & reg_write_in & ~misaligned;
  assign stall_out          = stall_c;
  assign misaligned_out     = misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a byte-level
// memory reference model and a variable-latency memory responder.

module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [31:0] alu_result_in;
  logic [31:0] write_data_in;
  logic [4:0]  write_register_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  mem_size_in;
  logic        mem_unsigned_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] alu_result_out;
  logic [4:0]  write_register_out;
  logic        mem_to_reg_out;
  logic [31:0] read_data_out;
  logic        reg_write_out;
  logic        stall_out;
  logic        misaligned_out;

  mem_stage dut (
    .clk                (clk),
    .reset              (reset),
    .alu_result_in      (alu_result_in),
    .write_data_in      (write_data_in),
    .write_register_in  (write_register_in),
    .reg_write_in       (reg_write_in),
    .mem_to_reg_in      (mem_to_reg_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_size_in        (mem_size_in),
    .mem_unsigned_in    (mem_unsigned_in),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_be            (dmem_be),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .alu_result_out     (alu_result_out),
    .write_register_out (write_register_out),
    .mem_to_reg_out     (mem_to_reg_out),
    .read_data_out      (read_data_out),
    .reg_write_out      (reg_write_out),
    .stall_out          (stall_out),
    .misaligned_out     (misaligned_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        is_mem;
    bit        is_load;
    bit        is_store;
    bit        mis;
    bit [31:0] alu;
    bit [4:0]  wreg;
    bit        m2r;
    bit        rw;
    bit [31:0] rd;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          lat_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit [7:0]    ref_mem [1024];
  logic [31:0] dmem_words [256];
  bit          mon_en     = 1'b0;
  bit          late_ack   = 1'b0;
  int          forced_lat = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference load: assemble nbytes little-endian bytes, then extend arithmetically
  function automatic bit [31:0] model_load(input int a, input int nbytes, input bit uns);
    longint v;
    v = 0;
    for (int k = 0; k < nbytes; k++) v += longint'(ref_mem[a + k]) << (8 * k);
    if (!uns && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
      v -= (longint'(1) << (8 * nbytes));
    return v[31:0];
  endfunction

  task automatic poke(input int waddr, input logic [31:0] w);
    dmem_words[waddr / 4] = w;
    for (int k = 0; k < 4; k++) ref_mem[waddr + k] = w[8*k +: 8];
  endtask

  task automatic drive_nop();
    alu_result_in     = 32'h0;
    write_data_in     = 32'h0;
    write_register_in = 5'd0;
    reg_write_in      = 1'b0;
    mem_to_reg_in     = 1'b0;
    mem_read_in       = 1'b0;
    mem_write_in      = 1'b0;
    mem_size_in       = 2'b00;
    mem_unsigned_in   = 1'b0;
  endtask

  // Present one instruction as EX/MEM would and hold it until it retires
  task automatic issue(input bit rd, input bit wr, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] wd, input bit rw,
                       input bit [4:0] wreg, input bit m2r, input int lat);
    exp_t e;
    int   nb;
    int   off;
    logic st;
    int   guard;
    @(negedge clk);
    alu_result_in     = a;
    write_data_in     = wd;
    write_register_in = wreg;
    reg_write_in      = rw;
    mem_to_reg_in     = m2r;
    mem_read_in       = rd;
    mem_write_in      = wr;
    mem_size_in       = sz;
    mem_unsigned_in   = uns;
    forced_lat        = lat;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    e.mis      = (rd || wr) && ((nb == 2 && a % 2 != 0) || (nb == 4 && off != 0));
    e.is_mem   = (rd || wr) && !e.mis;
    e.is_load  = e.is_mem && rd;
    e.is_store = e.is_mem && wr;
    e.alu      = a;
    e.wreg     = wreg;
    e.m2r      = m2r;
    e.rw       = rw && !e.mis;
    e.rd       = e.is_load ? model_load(int'(a), nb, uns) : 32'h0;
    e.addr     = a - (a % 4);
    e.be       = 4'b0000;
    e.wdata    = 32'h0;
    for (int k = 0; k < nb; k++) e.be[off + k] = 1'b1;
    for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = wd[8*(j % nb) +: 8];
    if (e.is_store)
      for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    exp_q.push_back(e);
    guard = 0;
    forever begin
      #1;
      st = stall_out;
      @(posedge clk);
      if (!st) break;
      @(negedge clk);
      guard++;
      if (guard > 60) begin
        failures++;
        $display("FAIL retire_timeout actual=stalled required=retired @%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "stall never released");
      end
    end
  endtask

  // Memory responder: random (or forced) latency, spurious acks while idle
  initial begin
    bit busy;
    int cnt;
    busy       = 1'b0;
    cnt        = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (reset) begin
        busy = 1'b0;
      end else if (late_ack) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end else if (dmem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
          lat_q.push_back(cnt);
        end
        if (cnt == 0) begin
          dmem_ack = 1'b1;
          busy     = 1'b0;
          if (dmem_we) begin
            for (int j = 0; j < 4; j++)
              if (dmem_be[j]) dmem_words[dmem_addr[9:2]][8*j +: 8] = dmem_wdata[8*j +: 8];
          end else begin
            dmem_rdata = dmem_words[dmem_addr[9:2]];
          end
        end else begin
          cnt--;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        dmem_ack = 1'b1;
      end
    end
  end

  // Monitor: compares each retiring instruction against the scoreboard head
  initial begin
    int   scnt;
    int   lat;
    exp_t e;
    scnt = 0;
    forever begin
      @(negedge clk);
      #3;
      if (!mon_en || reset) begin
        scnt = 0;
        continue;
      end
      if (exp_q.size() == 0) continue;
      e = exp_q[0];
      if (stall_out) begin
        scnt++;
        if (!e.is_mem) chk("stall_on_nonmem", {31'd0, stall_out}, 32'd0);
        chk("stall_rw_bubble", {31'd0, reg_write_out}, 32'd0);
        chk("req_held", {31'd0, dmem_req}, 32'd1);
        chk("dmem_addr", dmem_addr, e.addr);
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, e.is_store});
        if (e.is_store) begin
          chk("dmem_be", {28'd0, dmem_be}, {28'd0, e.be});
          chk("dmem_wdata", dmem_wdata, e.wdata);
        end
      end else begin
        void'(exp_q.pop_front());
        if (e.is_mem) begin
          chk("req_seen", lat_q.size(), 32'd1);
          lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
          chk("stall_cycles", scnt, lat + 1);
        end else begin
          chk("stall_cycles", scnt, 32'd0);
        end
        chk("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.rw});
        if (!e.is_store) chk("read_data_out", read_data_out, e.rd);
        chk("alu_result_out", alu_result_out, e.alu);
        chk("write_register_out", {27'd0, write_register_out}, {27'd0, e.wreg});
        chk("mem_to_reg_out", {31'd0, mem_to_reg_out}, {31'd0, e.m2r});
        chk("misaligned_out", {31'd0, misaligned_out}, {31'd0, e.mis});
        chk("req_idle_on_retire", {31'd0, dmem_req}, 32'd0);
        chk("be_idle_on_retire", {28'd0, dmem_be}, 32'd0);
        $display("txn alu=0x%08h rd=%0b wr=%0b mis=%0b stall=%0d data=0x%08h",
                 e.alu, e.is_load, e.is_store, e.mis, scnt, read_data_out);
        scnt = 0;
      end
    end
  end

  // Stimulus: directed cases, reset-abort scenario, then random stream
  initial begin
    bit        rd, wr, uns, rw;
    bit [1:0]  sz;
    bit [31:0] a;
    int        kind;
    reset = 1'b1;
    drive_nop();
    reg_write_in = 1'b1;
    for (int w = 0; w < 256; w++) poke(w * 4, $urandom);
    @(negedge clk);
    #3;
    chk("reset_req", {31'd0, dmem_req}, 32'd0);
    chk("reset_stall", {31'd0, stall_out}, 32'd0);
    chk("reset_rw_passthru", {31'd0, reg_write_out}, 32'd1);
    chk("reset_read_data", read_data_out, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // ALU op
    issue(0, 0, 2'b10, 0, 32'h1234, 32'h0, 1, 5'd3, 0, -1);
    // LB at 0x103, signed, ack 2 cycles after request
    poke(32'h100, 32'h80FFEEDD);
    issue(1, 0, 2'b00, 0, 32'h103, 32'h0, 1, 5'd4, 1, 2);
    // LHU at 0x102, ack in the request cycle
    poke(32'h100, 32'h9ABC5678);
    issue(1, 0, 2'b01, 1, 32'h102, 32'h0, 1, 5'd5, 1, 0);
    // SB at 0x101, then SW at 0x104, then read both back
    issue(0, 1, 2'b00, 0, 32'h101, 32'h000000AA, 0, 5'd0, 0, 1);
    issue(0, 1, 2'b10, 0, 32'h104, 32'hCAFEF00D, 0, 5'd0, 0, 0);
    issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 1, 5'd6, 1, 3);
    issue(1, 0, 2'b11, 0, 32'h104, 32'h0, 1, 5'd7, 1, 1);
    // Misaligned word load and half store
    issue(1, 0, 2'b10, 0, 32'h102, 32'h0, 1, 5'd8, 1, -1);
    issue(0, 1, 2'b01, 0, 32'h105, 32'h1234, 0, 5'd0, 0, -1);

    // Reset while waiting on a word load; a late ack must not complete it
    mon_en = 1'b0;
    @(negedge clk);
    alu_result_in = 32'h40; write_register_in = 5'd9; reg_write_in = 1'b1;
    mem_to_reg_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    mem_size_in = 2'b10; mem_unsigned_in = 1'b0; forced_lat = 10;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("rst_wait_stall", {31'd0, stall_out}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #3;
    chk("rst_cycle_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_cycle_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_cycle_rw", {31'd0, reg_write_out}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    drive_nop();
    late_ack = 1'b1;
    #3;
    chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("post_rst_stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    late_ack = 1'b0;
    #3;
    chk("late_ack_no_done", read_data_out, 32'd0);
    chk("late_ack_stall", {31'd0, stall_out}, 32'd0);
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    lat_q.delete();
    forced_lat = -1;
    mon_en = 1'b1;

    // Randomized stream
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 3));
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      a    = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~32'd1) : (a & ~32'd3);
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2);
      rw = rd ? 1'b1 : wr ? 1'b0 : 1'($urandom_range(0, 1));
      issue(rd, wr, sz, uns, a, $urandom, rw, 5'($urandom_range(0, 31)), rd, -1);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS pipeline, between the EX/MEM and MEM/WB latches. Turns load/store control from EX/MEM into byte-lane requests on a variable-latency data-memory handshake. Aligns and sign/zero-extends load data, and stalls the upstream pipeline while an access is outstanding. Detects misaligned halfword/word accesses and suppresses them. Outputs feed the MEM/WB latch inputs directly.

## Interface
Parameters:
- none; widths fixed by package: data 32 (`DATA_WIDTH`), register address 5 (`REG_ADDR_WIDTH`).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- alu_result_in  in  32  ALU result / effective address, from EX/MEM
- write_data_in  in  32  store data (rt), from EX/MEM
- write_register_in  in  5  destination register
- reg_write_in  in  1  register-write enable
- mem_to_reg_in  in  1  WB select (1 = memory)
- mem_read_in  in  1  load
- mem_write_in  in  1  store (mem_read_in and mem_write_in never both 1)
- mem_size_in  in  2  00 byte, 01 half, 10 word; 11 treated as word
- mem_unsigned_in  in  1  zero-extend loads (LBU/LHU)
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  {alu_result_in[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (bit i = byte i, little-endian)
- dmem_ack  in  1  one-cycle completion pulse; rdata valid same cycle
- dmem_rdata  in  32  read word
- alu_result_out, write_register_out, mem_to_reg_out  out  32/5/1  pass-through to MEM/WB
- read_data_out  out  32  extended load data to MEM/WB
- reg_write_out  out  1  gated register-write enable to MEM/WB
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misaligned_out  out  1  misaligned-access flag

## Operation
- FSM states: IDLE, WAIT, DONE. Reset -> IDLE; rdata_q <= 0.
- mem_op = (mem_read_in | mem_write_in) & ~misaligned.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Assert misaligned_out combinationally, force reg_write_out=0, no request, no stall. FSM stays IDLE.
- IDLE, mem_op=0: stall_out=0, dmem_req=0, reg_write_out=reg_write_in, read_data_out=0.
- IDLE, mem_op=1: dmem_req=1.
  - ack same cycle: capture rdata_q, -> DONE.
  - no ack: -> WAIT.
  - stall_out=1 in both cases.
- WAIT: dmem_req=1, stall_out=1. On ack: capture rdata_q, -> DONE.
- While stall_out=1: reg_write_out=0 (bubble into MEM/WB).
- DONE: dmem_req=0, stall_out=0, reg_write_out=reg_write_in, read_data_out=extend(rdata_q); -> IDLE unconditionally. The same instruction is never reissued.
- Store lanes:
  - byte: wdata={4{wd[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{wd[15:0]}}, be = addr[1] ? 1100 : 0011
  - word: wdata=wd, be=1111
  - dmem_be=0 when dmem_req=0.
- Load extract:
  - byte lane addr[1:0]; half lane addr[1]
  - sign-extend unless mem_unsigned_in; word unchanged.
- dmem_ack while dmem_req=0 is ignored.

## Timing
- Non-memory instructions: 0 added latency; outputs combinational from inputs.
- Memory op, ack after N cycles of req (N>=0): stall_out high N+1 cycles; DONE on cycle N+1; EX/MEM advances at the end of DONE.
- Minimum memory-op occupancy: 2 cycles.
- dmem_addr/we/wdata/be stay stable while dmem_req=1; inputs are held by the stall.
- Reset during WAIT/DONE: next cycle IDLE, dmem_req=0, stall_out=0, late ack ignored.
- Outputs during reset cycle: dmem_req=0, stall_out=0, misaligned_out driven from inputs, reg_write_out = reg_write_in & ~misaligned.

## Test plan
- ALU op, reg_write_in=1, alu_result_in=0x1234 -> alu_result_out=0x1234, reg_write_out=1, stall_out=0, dmem_req=0.
- LB at 0x103, mem_unsigned_in=0, rdata=0x80FFEEDD, ack 2 cycles after req -> stall_out high 3 cycles, reg_write_out=0 while stalled; DONE read_data_out=0xFFFFFF80, reg_write_out=1.
- LHU at 0x102, rdata=0x9ABC5678, ack in request cycle -> stall 1 cycle; DONE read_data_out=0x00009ABC.
- SB at 0x101, write_data_in=0x000000AA -> dmem_we=1, dmem_addr=0x100, dmem_be=0010, dmem_wdata=0xAAAAAAAA; SW at 0x104 -> be=1111.
- LW at 0x102 -> misaligned_out=1, dmem_req=0, stall_out=0, reg_write_out=0.
- LW in WAIT, reset asserted one cycle, ack arrives after reset -> IDLE, dmem_req=0, stall_out=0, rdata_q=0, no DONE.
